// File: rtl/seg7_scan_reader.sv
// Samples a multiplexed active-low 7-segment bus and rebuilds the displayed BCD digits,
// handing each complete frame to the consumer through a valid/ready handshake.
module seg7_scan_reader #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank_out,
  output logic [DIGITS-1:0]     err_out,
  output logic                  overrun
);

  localparam int         IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0] STAB = 8'(STABLE_CYCLES);

  logic [6:0]          seg_m, seg_s;
  logic [DIGITS-1:0]   an_m, an_s, inv;
  logic [DIGITS+6:0]   sample, prev;
  logic [7:0]          count, count_nxt;
  logic [DIGITS-1:0]   seen, seen_nxt;
  logic [IW-1:0]       idx;
  logic                sel, capture, complete, load, accept;
  logic [3:0]          dval;
  logic                dblank, derr;
  logic [4*DIGITS-1:0] hold_bcd, hold_bcd_nxt;
  logic [DIGITS-1:0]   hold_blank, hold_blank_nxt, hold_err, hold_err_nxt;

  assign sample = {an_s, seg_s};
  assign inv    = ~an_s;

  // A digit is selected only when exactly one anode is driven low.
  always_comb begin
    sel = (inv != '0) && ((inv & (inv - DIGITS'(1))) == '0);
    idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_s[i]) idx = IW'(i);
    end
  end

  always_comb begin
    dval   = 4'hE;
    dblank = 1'b0;
    derr   = 1'b0;
    case (seg_s)
      7'h40: dval = 4'd0;
      7'h79: dval = 4'd1;
      7'h24: dval = 4'd2;
      7'h30: dval = 4'd3;
      7'h19: dval = 4'd4;
      7'h12: dval = 4'd5;
      7'h02: dval = 4'd6;
      7'h78: dval = 4'd7;
      7'h00: dval = 4'd8;
      7'h10: dval = 4'd9;
      7'h7F: begin dval = 4'hF; dblank = 1'b1; end
      default: derr = 1'b1;
    endcase
  end

  // Capture only on the edge the count first reaches its ceiling, so a long dwell yields one capture.
  always_comb begin
    if (!sel)                count_nxt = '0;
    else if (sample != prev) count_nxt = 8'd1;
    else if (count >= STAB)  count_nxt = STAB;
    else                     count_nxt = count + 8'd1;
    capture = sel && (count_nxt == STAB) && (count != STAB);
  end

  always_comb begin
    hold_bcd_nxt   = hold_bcd;
    hold_blank_nxt = hold_blank;
    hold_err_nxt   = hold_err;
    seen_nxt       = seen;
    if (capture) begin
      hold_bcd_nxt[{idx, 2'b00} +: 4] = dval;
      hold_blank_nxt[idx]             = dblank;
      hold_err_nxt[idx]               = derr;
      seen_nxt[idx]                   = 1'b1;
    end
    complete = capture && (&seen_nxt);
    accept   = out_valid && out_ready;
    load     = complete && (!out_valid || out_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_m      <= '1;
      seg_s      <= '1;
      an_m       <= '1;
      an_s       <= '1;
      prev       <= '1;
      count      <= '0;
      seen       <= '0;
      hold_bcd   <= '0;
      hold_blank <= '0;
      hold_err   <= '0;
      out_valid  <= 1'b0;
      bcd_out    <= '0;
      blank_out  <= '0;
      err_out    <= '0;
      overrun    <= 1'b0;
    end else begin
      seg_m      <= seg_in;
      seg_s      <= seg_m;
      an_m       <= an_in;
      an_s       <= an_m;
      prev       <= sample;
      count      <= count_nxt;
      seen       <= complete ? '0 : seen_nxt;
      hold_bcd   <= hold_bcd_nxt;
      hold_blank <= hold_blank_nxt;
      hold_err   <= hold_err_nxt;
      if (load) begin
        bcd_out   <= hold_bcd_nxt;
        blank_out <= hold_blank_nxt;
        err_out   <= hold_err_nxt;
        out_valid <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
      // A completed frame that cannot be loaded is dropped; an accept always clears the flag.
      if (accept)                 overrun <= 1'b0;
      else if (complete && !load) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Self-checking bench for seg7_scan_reader: expected frames are queued as stimulus is driven
// and compared against frames the monitor sees accepted.
module tb_seg7_scan_reader;

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic [3:0]  err;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_in = 7'h7F;
  logic [3:0]  an_in = 4'hF;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] bcd_out;
  logic [3:0]  blank_out;
  logic [3:0]  err_out;
  logic        overrun;

  int errors = 0;
  int checks = 0;
  frame_t exp_q[$];
  frame_t obs_q[$];

  seg7_scan_reader #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in), .out_ready(out_ready),
    .out_valid(out_valid), .bcd_out(bcd_out), .blank_out(blank_out),
    .err_out(err_out), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Pre-edge values are read here, so this records exactly the frames that get accepted.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) obs_q.push_back({bcd_out, blank_out, err_out});
  end

  task automatic drive_digit(input int d, input logic [6:0] s, input int n);
    an_in  = ~(4'b0001 << d);
    seg_in = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; an_in = 4'hF; seg_in = 7'h7F; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    frame_t e, o;
    do_reset();
    out_ready = 1'b0;
    for (int d = 0; d < 4; d++) drive_digit(d, 7'h12, 8);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL reset_pre_valid got=%b want=1", out_valid); end
    drive_digit(0, 7'h79, 8);
    drive_digit(1, 7'h79, 8);
    rst = 1'b1; an_in = 4'hF; seg_in = 7'h7F;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++;
    if (bcd_out !== 16'h0) begin errors++; $display("FAIL reset_bcd got=%h want=0000", bcd_out); end
    checks++;
    if (blank_out !== 4'h0 || err_out !== 4'h0) begin
      errors++; $display("FAIL reset_flags blank=%b err=%b want=0000/0000", blank_out, err_out);
    end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    drive_digit(2, 7'h30, 8);
    drive_digit(3, 7'h30, 8);
    checks++;
    if (obs_q.size() != 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_partial frames=%0d valid=%b want=0/0", obs_q.size(), out_valid);
    end
    exp_q.push_back({16'h3344, 4'h0, 4'h0});
    drive_digit(0, 7'h19, 8);
    drive_digit(1, 7'h19, 8);
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL reset_recapture_count got=%0d want=1", obs_q.size());
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL reset_recapture_frame got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_scan();
    frame_t e, o;
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back({16'h4321, 4'h0, 4'h0});
    drive_digit(0, 7'h79, 8);
    drive_digit(1, 7'h24, 8);
    drive_digit(2, 7'h30, 8);
    an_in = 4'b0111; seg_in = 7'h19;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 5) begin
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL scan_early_valid got=%b want=0", out_valid); end
      end
      if (i == 6) begin
        checks++;
        if (out_valid !== 1'b1 || bcd_out !== 16'h4321) begin
          errors++; $display("FAIL scan_latency valid=%b bcd=%h want=1/4321", out_valid, bcd_out);
        end
      end
      if (i == 7) begin
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL scan_pulse valid=%b want=0", out_valid); end
      end
    end
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL scan_count got=%0d want=1", obs_q.size());
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL scan_frame got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_short_dwell();
    frame_t e, o;
    do_reset();
    out_ready = 1'b1;
    drive_digit(0, 7'h12, 8);
    drive_digit(1, 7'h02, 3);
    drive_digit(2, 7'h78, 8);
    drive_digit(3, 7'h00, 8);
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL short_first_pass frames=%0d want=0", obs_q.size()); end
    exp_q.push_back({16'h8765, 4'h0, 4'h0});
    drive_digit(0, 7'h12, 8);
    drive_digit(1, 7'h02, 8);
    drive_digit(2, 7'h78, 8);
    drive_digit(3, 7'h00, 8);
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL short_count got=%0d want=1", obs_q.size());
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL short_frame got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_blank_err();
    frame_t e, o;
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back({16'hEF00, 4'b0100, 4'b1000});
    drive_digit(0, 7'h40, 8);
    drive_digit(1, 7'h40, 8);
    drive_digit(2, 7'h7F, 8);
    drive_digit(3, 7'h7E, 8);
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL blank_err_count got=%0d want=1", obs_q.size());
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o.bcd !== e.bcd) begin errors++; $display("FAIL blank_err_bcd got=%h want=%h", o.bcd, e.bcd); end
      checks++;
      if (o.blank !== e.blank) begin errors++; $display("FAIL blank_err_blank got=%b want=%b", o.blank, e.blank); end
      checks++;
      if (o.err !== e.err) begin errors++; $display("FAIL blank_err_err got=%b want=%b", o.err, e.err); end
    end
  endtask

  task automatic test_overrun();
    frame_t e, o;
    do_reset();
    out_ready = 1'b0;
    exp_q.push_back({16'h1111, 4'h0, 4'h0});
    for (int d = 0; d < 4; d++) drive_digit(d, 7'h79, 8);
    checks++;
    if (out_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_first valid=%b ovr=%b want=1/0", out_valid, overrun);
    end
    for (int d = 0; d < 4; d++) drive_digit(d, 7'h24, 8);
    checks++;
    if (bcd_out !== 16'h1111) begin errors++; $display("FAIL overrun_hold got=%h want=1111", bcd_out); end
    checks++;
    if (overrun !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL overrun_set ovr=%b valid=%b want=1/1", overrun, out_valid);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_accept valid=%b ovr=%b want=0/0", out_valid, overrun);
    end
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL overrun_count got=%0d want=1", obs_q.size());
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL overrun_frame got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_bad_anodes();
    frame_t e, o;
    do_reset();
    out_ready = 1'b1;
    an_in = 4'b1100; seg_in = 7'h79;
    repeat (10) @(negedge clk);
    an_in = 4'b1111;
    repeat (10) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || obs_q.size() != 0) begin
      errors++; $display("FAIL bad_an_idle valid=%b frames=%0d want=0/0", out_valid, obs_q.size());
    end
    drive_digit(0, 7'h02, 8);
    drive_digit(1, 7'h02, 8);
    drive_digit(2, 7'h02, 8);
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL bad_an_seen frames=%0d want=0", obs_q.size()); end
    exp_q.push_back({16'h7666, 4'h0, 4'h0});
    drive_digit(3, 7'h78, 8);
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL bad_an_count got=%0d want=1", obs_q.size());
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL bad_an_frame got=%h want=%h", o, e); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_scan();
    test_short_dwell();
    test_blank_err();
    test_overrun();
    test_bad_anodes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Receive-side counterpart of the team's BCD-to-7-segment decoder.
- Samples a multiplexed, active-low 7-segment display bus: segments plus per-digit anode enables.
- Reconstructs the BCD digits being displayed and presents one complete frame through a valid/ready handshake.
- Used for display loopback checking and for reading scanned displays from external boards.

Parameters:
- DIGITS, 4, number of multiplexed digits (anodes); range 1..8.
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before a digit is captured; range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- seg_in  input  7  segments, active-low; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
- an_in  input  DIGITS  digit enables, active-low, expected one-hot-low.
- out_ready  input  1  consumer accepts the frame when high with out_valid.
- out_valid  output  1  frame available.
- bcd_out  output  4*DIGITS  digit i occupies bits [4i+3:4i].
- blank_out  output  DIGITS  digit i was all segments off.
- err_out  output  DIGITS  digit i pattern not in the decode table.
- overrun  output  1  sticky; a completed frame was dropped.

Behaviour:
- Reset (async assert, synchronous release):
  - out_valid=0, bcd_out=0, blank_out=0, err_out=0, overrun=0.
  - Synchronizer flops=all 1s; seen mask=0; stability count=0; per-digit holding registers cleared.
  - A partial frame in progress at reset is discarded.
- Synchronization: seg_in and an_in each pass through 2 flip-flop stages (seg_s, an_s). All logic below uses the synchronized values.
- Digit select:
  - Valid only when exactly one bit of an_s is 0; idx is that bit's position.
  - Zero or multiple low bits: no selection, count forced to 0, no capture.
- Stability, evaluated every edge:
  - sample={an_s,seg_s}; prev<=sample.
  - If selected and sample!=prev: count<=1.
  - If selected and sample==prev: count<=min(count+1, STABLE_CYCLES).
  - Capture fires on the edge where count's next value equals STABLE_CYCLES and its current value does not. This gives one capture per dwell; a long dwell never re-captures.
- Decode on capture, from seg_s:
  - 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10→9.
  - 0x7F→value 0xF, blank=1.
  - Any other pattern→value 0xE, err=1.
  - The digit's blank/err bits are otherwise 0.
  - The holding register for idx is written, overwriting any earlier capture of that digit in the same frame, and seen[idx] is set.
- Frame completion occurs when seen, including this edge's capture, is all 1s. On that edge seen is cleared.
  - If out_valid=0, or out_valid=1 with out_ready=1: bcd_out, blank_out and err_out load the holding values (including the current capture) and out_valid<=1.
  - Otherwise the outputs are unchanged and overrun<=1.
- Handshake:
  - out_valid && out_ready with no simultaneous frame completion: out_valid<=0.
  - Outputs stay stable while out_valid=1 and out_ready=0.
  - overrun clears on any accept edge (out_valid && out_ready), including one that coincides with a frame load.
- Latency: a settled digit is captured 2+STABLE_CYCLES edges after its inputs change (6 with defaults). out_valid rises on the capture edge of the final digit of a frame.

Test Plan:
- Reset mid-activity, with rst high for 2 cycles -> all outputs 0; out_valid=0; overrun=0; no frame is produced until all DIGITS digits are recaptured.
- out_ready=1; scan an0..an3 with seg 0x79, 0x24, 0x30, 0x19, each held 8 cycles -> single out_valid pulse with bcd_out=16'h4321, blank_out=0, err_out=0, asserted 6 edges after the an3 pattern is applied.
- Digit 1 held only 3 cycles (STABLE_CYCLES=4), other digits held 8 cycles -> no frame on that pass; the frame appears on the next full pass with correct values.
- Digit 2 = 0x7F, digit 3 = 0x7E, digits 0/1 = 0x40 -> bcd_out=16'hEF00, blank_out=4'b0100, err_out=4'b1000.
- out_ready=0 across two complete frames (16'h1111 then 16'h2222) -> bcd_out holds 16'h1111 and overrun=1. Then raise out_ready for 1 cycle -> out_valid=0 and overrun=0 on the next edge.
- an_in=4'b1100 (two digits low) for 10 cycles, then 4'b1111 for 10 cycles -> no capture, seen unchanged, out_valid stays 0.
